// File: rtl/sat_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sat_pipe : two-stage, multi-channel signed/unsigned saturation with
//            per-sample clip flags, sticky flags and saturating event counters.
// Revision  : 1.0
// ----------------------------------------------------------------------------
module sat_pipe #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 10,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld,
  input  logic [NUM_CH*IN_W-1:0]    in_data,
  input  logic [NUM_CH-1:0]         signed_mode,
  input  logic                      clr_stat,
  output logic                      out_vld,
  output logic [NUM_CH*OUT_W-1:0]   out_data,
  output logic [NUM_CH-1:0]         sat_hi,
  output logic [NUM_CH-1:0]         sat_lo,
  output logic [NUM_CH-1:0]         sat_sticky,
  output logic [NUM_CH*CNT_W-1:0]   sat_cnt
);

  localparam logic [OUT_W-1:0] MAX_U   = '1;
  localparam logic [OUT_W-1:0] MAX_S   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_S   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                   s1_vld;
  logic [NUM_CH*IN_W-1:0] s1_data;
  logic [NUM_CH-1:0]      s1_mode;
  logic                   vld_q;

  // Stage 1: capture the sample together with its per-channel mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_mode <= '0;
      vld_q   <= 1'b0;
    end else begin
      s1_vld <= in_vld;
      vld_q  <= s1_vld;
      if (in_vld) begin
        s1_data <= in_data;
        s1_mode <= signed_mode;
      end
    end
  end

  assign out_vld = vld_q;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [IN_W-1:0]    din;
      logic [IN_W-OUT_W:0] top_s;
      logic               fits_s;
      logic               ovf_u;
      logic               hi;
      logic               lo;
      logic               clip;
      logic [OUT_W-1:0]   res;
      logic [OUT_W-1:0]   data_q;
      logic               hi_q;
      logic               lo_q;
      logic               sticky_q;
      logic [CNT_W-1:0]   cnt_q;

      assign din    = s1_data[c*IN_W +: IN_W];
      assign top_s  = din[IN_W-1:OUT_W-1];
      assign fits_s = (&top_s) | ~(|top_s);
      assign ovf_u  = |din[IN_W-1:OUT_W];

      always_comb begin
        hi  = 1'b0;
        lo  = 1'b0;
        res = din[OUT_W-1:0];
        if (s1_mode[c]) begin
          if (!fits_s) begin
            if (din[IN_W-1]) begin
              lo  = 1'b1;
              res = MIN_S;
            end else begin
              hi  = 1'b1;
              res = MAX_S;
            end
          end
        end else if (ovf_u) begin
          hi  = 1'b1;
          res = MAX_U;
        end
      end

      assign clip = s1_vld & (hi | lo);

      // Stage 2: clipped data, flags and statistics (clear wins, then count).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q   <= '0;
          hi_q     <= 1'b0;
          lo_q     <= 1'b0;
          sticky_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          hi_q <= s1_vld & hi;
          lo_q <= s1_vld & lo;
          if (s1_vld) data_q <= res;
          if (clr_stat) begin
            sticky_q <= clip;
            cnt_q    <= clip ? CNT_W'(1) : '0;
          end else if (clip) begin
            sticky_q <= 1'b1;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      end

      assign out_data[c*OUT_W +: OUT_W] = data_q;
      assign sat_hi[c]                  = hi_q;
      assign sat_lo[c]                  = lo_q;
      assign sat_sticky[c]              = sticky_q;
      assign sat_cnt[c*CNT_W +: CNT_W]  = cnt_q;
    end
  endgenerate

endmodule
`default_nettype wire
